// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port among cpu, acl and dma with a response watchdog
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_valid,
  output logic                  cpu_err,
  input  logic                  acl_req,
  input  logic                  acl_wr_en,
  input  logic [ADDR_WIDTH-1:0] acl_addr,
  input  logic [DATA_WIDTH-1:0] acl_wdata,
  output logic                  acl_gnt,
  output logic                  acl_valid,
  output logic                  acl_err,
  input  logic                  dma_req,
  input  logic                  dma_wr_en,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_valid,
  output logic                  dma_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            owner,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [1:0] ptr, p1, p2, win;
  logic [2:0] req, gnt_r, valid_r, err_r;
  logic [31:0] wd_cnt;
  logic any, act, wd_hit, sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  assign req = {dma_req, acl_req, cpu_req};
  assign {dma_gnt, acl_gnt, cpu_gnt}       = gnt_r;
  assign {dma_valid, acl_valid, cpu_valid} = valid_r;
  assign {dma_err, acl_err, cpu_err}       = err_r;
  always_comb begin
    any       = |req;
    act       = (state == ISSUE) || (state == WAIT);
    // expiry is flagged in the cycle whose increment would bring the counter to TIMEOUT
    wd_hit    = (TIMEOUT != 0) && (wd_cnt == 32'(TIMEOUT - 1));
    p1        = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    p2        = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
    win       = req[ptr] ? ptr : req[p1] ? p1 : p2;
    sel_wr    = (win == 2'd0) ? cpu_wr_en : (win == 2'd1) ? acl_wr_en : dma_wr_en;
    sel_addr  = (win == 2'd0) ? cpu_addr  : (win == 2'd1) ? acl_addr  : dma_addr;
    sel_wdata = (win == 2'd0) ? cpu_wdata : (win == 2'd1) ? acl_wdata : dma_wdata;
    state_n   = (state == IDLE) ? (any ? ISSUE : IDLE) :
                (state == RESP) ? IDLE :
                (mem_valid || wd_hit) ? RESP : WAIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      wd_cnt    <= '0;
      gnt_r     <= '0;
      valid_r   <= '0;
      err_r     <= '0;
      rdata     <= '0;
      owner     <= 2'd0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= state_n;
      busy    <= state_n != IDLE;
      mem_en  <= state_n == ISSUE;
      gnt_r   <= (state == IDLE && any) ? 3'(1) << win : '0;
      valid_r <= (act && mem_valid) ? 3'(1) << owner : '0;
      err_r   <= (act && !mem_valid && wd_hit) ? 3'(1) << owner : '0;
      if (state == IDLE && any) begin
        owner     <= win;
        ptr       <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        mem_wr_en <= sel_wr;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        wd_cnt    <= '0;
      end
      if (act && !mem_valid) wd_cnt <= wd_cnt + 32'd1;
      if (act && mem_valid && !mem_wr_en) rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with an 8-cycle watchdog
module tb_mem_arbiter;
  logic clk = 0, rst_n = 0;
  logic cpu_req = 0, cpu_wr_en = 0, acl_req = 0, acl_wr_en = 0, dma_req = 0, dma_wr_en = 0;
  logic [27:0] cpu_addr = 0, acl_addr = 0, dma_addr = 0, mem_addr;
  logic [31:0] cpu_wdata = 0, acl_wdata = 0, dma_wdata = 0, mem_wdata, rdata, mem_rdata = 0;
  logic cpu_gnt, cpu_valid, cpu_err, acl_gnt, acl_valid, acl_err, dma_gnt, dma_valid, dma_err;
  logic [1:0] owner;
  logic busy, mem_en, mem_wr_en, mem_valid = 0;
  int nerr = 0, nchk = 0;
  logic [1:0] exp_own [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [27:0] exp_addr [3] = '{28'h100, 28'h200, 28'h300};

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(28), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_err(cpu_err),
    .acl_req(acl_req), .acl_wr_en(acl_wr_en), .acl_addr(acl_addr), .acl_wdata(acl_wdata),
    .acl_gnt(acl_gnt), .acl_valid(acl_valid), .acl_err(acl_err),
    .dma_req(dma_req), .dma_wr_en(dma_wr_en), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_valid(dma_valid), .dma_err(dma_err),
    .rdata(rdata), .owner(owner), .busy(busy), .mem_en(mem_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid));

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_outs", {cpu_gnt, cpu_valid, cpu_err, acl_gnt, acl_valid, acl_err, dma_gnt, dma_valid, dma_err, mem_en, mem_wr_en, owner}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", {4'd0, mem_addr}, 0);
    rst_n = 1;
    step();
    // single cpu read, memory answers 3 cycles after mem_en
    cpu_req = 1; cpu_addr = 28'h10;
    step();
    chk("rd_gnt", {cpu_gnt, acl_gnt, dma_gnt, mem_en, mem_wr_en, busy}, 6'b100101);
    chk("rd_addr", {4'd0, mem_addr}, 32'h10);
    chk("rd_owner", {30'd0, owner}, 0);
    step();
    chk("rd_gnt_pulse", {cpu_gnt, mem_en}, 0);
    chk("rd_addr_hold", {4'd0, mem_addr}, 32'h10);
    step(2);
    chk("rd_no_early_valid", {31'd0, cpu_valid}, 0);
    mem_valid = 1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("rd_valid", {cpu_valid, cpu_err, acl_valid, acl_err, dma_valid, dma_err}, 6'b100000);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    cpu_req = 0; mem_valid = 0;
    step();
    chk("rd_idle", {cpu_valid, busy}, 0);
    // zero-latency acl read (ptr now favours acl), leaves rdata = 0xA
    acl_req = 1; acl_addr = 28'h30;
    step();
    chk("zl_gnt", {cpu_gnt, acl_gnt, dma_gnt, mem_en}, 4'b0101);
    chk("zl_owner", {30'd0, owner}, 1);
    mem_valid = 1; mem_rdata = 32'hA;
    step();
    chk("zl_valid_next", {acl_valid, acl_err, mem_en}, 3'b100);
    chk("zl_rdata", rdata, 32'hA);
    acl_req = 0; mem_valid = 0;
    step();
    chk("zl_idle", {31'd0, busy}, 0);
    // dma write must not disturb rdata
    dma_req = 1; dma_wr_en = 1; dma_addr = 28'h20; dma_wdata = 32'h5; mem_rdata = 32'h77;
    step();
    chk("wr_gnt", {dma_gnt, mem_en, mem_wr_en}, 3'b111);
    chk("wr_addr", {4'd0, mem_addr}, 32'h20);
    chk("wr_wdata", mem_wdata, 32'h5);
    chk("wr_owner", {30'd0, owner}, 2);
    step();
    chk("wr_wait_hold", {mem_en, mem_wr_en, dma_gnt}, 3'b010);
    mem_valid = 1;
    step();
    chk("wr_valid", {dma_valid, dma_err}, 2'b10);
    chk("wr_rdata_kept", rdata, 32'hA);
    dma_req = 0; dma_wr_en = 0; mem_valid = 0;
    step();
    // watchdog: gnt at E+1, err at E+9
    acl_req = 1; acl_addr = 28'h40;
    step();
    chk("wd_gnt", {31'd0, acl_gnt}, 1);
    step(7);
    chk("wd_no_early_err", {acl_err, acl_valid, busy}, 3'b001);
    step();
    chk("wd_err", {acl_err, acl_valid, cpu_err, dma_err}, 4'b1000);
    acl_req = 0;
    step();
    chk("wd_err_pulse", {acl_err, busy}, 0);
    // watchdog rerun: mem_valid in the expiry cycle wins
    acl_req = 1;
    step();
    chk("wd2_gnt", {31'd0, acl_gnt}, 1);
    step(7);
    mem_valid = 1; mem_rdata = 32'h1234;
    step();
    chk("wd2_valid", {acl_valid, acl_err}, 2'b10);
    chk("wd2_rdata", rdata, 32'h1234);
    acl_req = 0; mem_valid = 0;
    step();
    // reset during WAIT with acl as owner
    acl_req = 1;
    step(2);
    chk("rw_waiting", {busy, mem_en, 28'd0, owner}, {2'b10, 28'd0, 2'd1});
    rst_n = 0;
    #1;
    chk("rw_async", {busy, owner, mem_wr_en}, 0);
    chk("rw_rdata", rdata, 0);
    acl_req = 0;
    step(2);
    rst_n = 1;
    step();
    mem_valid = 1;
    step();
    chk("rw_stray", {cpu_valid, cpu_err, acl_valid, acl_err, dma_valid, dma_err, busy}, 0);
    mem_valid = 0;
    // all three request continuously: cpu, acl, dma, cpu
    cpu_req = 1; acl_req = 1; dma_req = 1;
    cpu_addr = 28'h100; acl_addr = 28'h200; dma_addr = 28'h300;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_gnt%0d", i), {29'd0, dma_gnt, acl_gnt, cpu_gnt}, 32'(1) << exp_own[i]);
      chk($sformatf("rr_owner%0d", i), {30'd0, owner}, {30'd0, exp_own[i]});
      chk($sformatf("rr_addr%0d", i), {4'd0, mem_addr}, {4'd0, exp_addr[exp_own[i]]});
      mem_valid = 1;
      step();
      chk($sformatf("rr_valid%0d", i), {29'd0, dma_valid, acl_valid, cpu_valid}, 32'(1) << exp_own[i]);
      mem_valid = 0;
      step();
    end
    cpu_req = 0; acl_req = 0; dma_req = 0;
    step(2);
    chk("end_idle", {31'd0, busy}, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
